// File: rtl/pll_clkgen_pkg.sv
// Shared types and helpers for the multi-channel divided-clock / clock-enable generator.
package pll_clkgen_pkg;

    localparam int unsigned DIV_W = 16;

    typedef logic [DIV_W-1:0] div_t;

    typedef struct packed {
        div_t div;
        div_t phase;
    } chan_cfg_t;

    // A phase that cannot be reached within the period falls back to 0.
    function automatic div_t eff_phase(input div_t div, input div_t phase);
        return (phase < div) ? phase : '0;
    endfunction

endpackage

// File: rtl/pll_clkgen_chan.sv
// One output channel: divisor/phase registers, period counter and registered enable/clock decode.
module pll_clkgen_chan
    import pll_clkgen_pkg::*;
#(
    parameter div_t DEFAULT_DIV = div_t'(1)
) (
    input  logic      i_clk,
    input  logic      i_rst,
    input  logic      i_resync,
    input  logic      i_load,
    input  chan_cfg_t i_cfg,
    output logic      o_clk_en,
    output logic      o_outclk
);

    chan_cfg_t r_cfg;
    div_t      r_cnt;
    logic      r_clk_en;
    logic      r_outclk;

    div_t w_pe;
    div_t w_cnt_nxt;
    logic w_clk_en_d;
    logic w_outclk_d;

    always_comb begin
        w_pe       = eff_phase(r_cfg.div, r_cfg.phase);
        w_clk_en_d = (r_cfg.div != '0) && (r_cnt == w_pe);
        w_outclk_d = (r_cfg.div >= div_t'(2)) && (r_cnt < (r_cfg.div >> 1));
        // D of 0 or 1 parks the counter at 0; otherwise count 0..D-1.
        if ((r_cfg.div < div_t'(2)) || (r_cnt >= (r_cfg.div - div_t'(1)))) begin
            w_cnt_nxt = '0;
        end else begin
            w_cnt_nxt = r_cnt + div_t'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cfg.div   <= DEFAULT_DIV;
            r_cfg.phase <= '0;
            r_cnt       <= '0;
            r_clk_en    <= 1'b0;
            r_outclk    <= 1'b0;
        end else begin
            r_clk_en <= w_clk_en_d;
            r_outclk <= w_outclk_d;
            if (i_load) begin
                r_cfg <= i_cfg;
            end
            r_cnt <= i_resync ? '0 : w_cnt_nxt;
        end
    end

    assign o_clk_en = r_clk_en;
    assign o_outclk = r_outclk;

endmodule

// File: rtl/pll_clkgen_multi.sv
// Multi-channel programmable clock-enable / divided-clock generator with a supervised locked flag.
// DIV_W must equal pll_clkgen_pkg::DIV_W; the channel registers are sized from the package.
module pll_clkgen_multi #(
    parameter int unsigned                    NUM_CLOCKS  = 3,
    parameter int unsigned                    DIV_W       = 16,
    parameter int unsigned                    LOCK_CYCLES = 1024,
    parameter logic [NUM_CLOCKS*DIV_W-1:0]    DEFAULT_DIV = {16'd5, 16'd2, 16'd1},
    localparam int unsigned                   SEL_W       = (NUM_CLOCKS > 1) ?
                                                            $clog2(NUM_CLOCKS) : 1
) (
    input  logic                  i_refclk,
    input  logic                  i_rst,
    input  logic                  i_cfg_we,
    input  logic [SEL_W-1:0]      i_cfg_sel,
    input  logic [DIV_W-1:0]      i_cfg_div,
    input  logic [DIV_W-1:0]      i_cfg_phase,
    output logic [NUM_CLOCKS-1:0] o_clk_en,
    output logic [NUM_CLOCKS-1:0] o_outclk,
    output logic                  o_locked
);

    localparam int unsigned LOCK_W = $clog2(LOCK_CYCLES + 1);

    pll_clkgen_pkg::chan_cfg_t w_cfg;
    logic                      w_resync;
    logic [NUM_CLOCKS-1:0]     w_load;

    logic [LOCK_W-1:0] r_lock_cnt;
    logic              r_locked;

    assign w_cfg = '{div: i_cfg_div, phase: i_cfg_phase};

    // Out-of-range selects are dropped entirely: no load and no resync.
    assign w_resync = i_cfg_we && ({1'b0, i_cfg_sel} < (SEL_W + 1)'(NUM_CLOCKS));

    for (genvar g = 0; g < NUM_CLOCKS; g++) begin : g_chan
        assign w_load[g] = w_resync && (i_cfg_sel == SEL_W'(g));

        pll_clkgen_chan #(
            .DEFAULT_DIV (DEFAULT_DIV[g*DIV_W +: DIV_W])
        ) u_chan (
            .i_clk    (i_refclk),
            .i_rst    (i_rst),
            .i_resync (w_resync),
            .i_load   (w_load[g]),
            .i_cfg    (w_cfg),
            .o_clk_en (o_clk_en[g]),
            .o_outclk (o_outclk[g])
        );
    end

    // Lock counter stops once locked; any resync restarts the full interval.
    always_ff @(posedge i_refclk) begin
        if (i_rst || w_resync) begin
            r_lock_cnt <= '0;
            r_locked   <= 1'b0;
        end else if (!r_locked) begin
            if (r_lock_cnt == LOCK_W'(LOCK_CYCLES - 1)) begin
                r_locked <= 1'b1;
            end else begin
                r_lock_cnt <= r_lock_cnt + LOCK_W'(1);
            end
        end
    end

    assign o_locked = r_locked;

endmodule

// File: tb/tb_pll_clkgen_multi.sv
// Self-checking bench: directed scenarios with literal expectations plus a random soak vs. a model.
module tb_pll_clkgen_multi;

    localparam int N    = 3;
    localparam int DW   = 16;
    localparam int LOCK = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          we;
    logic [1:0]    sel;
    logic [DW-1:0] cdiv;
    logic [DW-1:0] cph;
    logic [N-1:0]  en;
    logic [N-1:0]  oc;
    logic          lk;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pll_clkgen_multi #(
        .NUM_CLOCKS  (N),
        .DIV_W       (DW),
        .LOCK_CYCLES (LOCK),
        .DEFAULT_DIV ({16'd5, 16'd2, 16'd1})
    ) dut (
        .i_refclk    (clk),
        .i_rst       (rst),
        .i_cfg_we    (we),
        .i_cfg_sel   (sel),
        .i_cfg_div   (cdiv),
        .i_cfg_phase (cph),
        .o_clk_en    (en),
        .o_outclk    (oc),
        .o_locked    (lk)
    );

    // Reference model: every channel has been running for m_t cycles since the last sync,
    // so its position in the period is simply m_t mod D.
    int           m_div[N];
    int           m_ph[N];
    int           m_t;
    int           m_since;
    logic [N-1:0] m_en;
    logic [N-1:0] m_oc;
    bit           m_valid = 1'b0;

    function automatic int def_div(input int i);
        case (i)
            0:       return 1;
            1:       return 2;
            default: return 5;
        endcase
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                m_div[i] = def_div(i);
                m_ph[i]  = 0;
            end
            m_t     = 0;
            m_since = 0;
            m_en    = '0;
            m_oc    = '0;
            m_valid = 1'b1;
        end else if (m_valid) begin
            for (int i = 0; i < N; i++) begin
                int d, c, pe;
                d        = m_div[i];
                c        = (d >= 2) ? (m_t % d) : 0;
                pe       = (m_ph[i] < d) ? m_ph[i] : 0;
                m_en[i]  = (d >= 1) && (c == pe);
                m_oc[i]  = (d >= 2) && (c < d / 2);
            end
            if (we && (sel < N)) begin
                m_div[sel] = int'(cdiv);
                m_ph[sel]  = int'(cph);
                m_t        = 0;
                m_since    = 0;
            end else begin
                m_t++;
                if (m_since < LOCK) m_since++;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (m_valid) begin
            chk("model_clk_en", 32'(en), 32'(m_en));
            chk("model_outclk", 32'(oc), 32'(m_oc));
            chk("model_locked", 32'(lk), 32'(m_since >= LOCK));
        end
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wr(input int s, input int d, input int p);
        we   = 1'b1;
        sel  = 2'(s);
        cdiv = DW'(d);
        cph  = DW'(p);
        tick();
        we   = 1'b0;
    endtask

    logic [N-1:0] ens[0:40];
    logic [N-1:0] ocs[0:40];
    logic         lks[0:40];

    task automatic record(input int n);
        for (int k = 1; k <= n; k++) begin
            tick();
            ens[k] = en;
            ocs[k] = oc;
            lks[k] = lk;
        end
    endtask

    initial begin
        rst  = 1'b1;
        we   = 1'b0;
        sel  = '0;
        cdiv = '0;
        cph  = '0;
        repeat (2) @(negedge clk);
        chk("rst_clk_en", 32'(en), 32'd0);
        chk("rst_outclk", 32'(oc), 32'd0);
        chk("rst_locked", 32'(lk), 32'd0);
        rst = 1'b0;

        // Defaults {5,2,1} after reset release.
        record(20);
        chk("d1_ch0_en", 32'(ens[1][0]), 32'd1);
        chk("d1_ch0_en7", 32'(ens[7][0]), 32'd1);
        chk("d1_ch0_oc", 32'(ocs[3][0]), 32'd0);
        chk("d2_ch1_oc1", 32'(ocs[1][1]), 32'd1);
        chk("d2_ch1_oc2", 32'(ocs[2][1]), 32'd0);
        chk("d2_ch1_oc3", 32'(ocs[3][1]), 32'd1);
        chk("d5_ch2_oc", 32'({ocs[1][2], ocs[2][2], ocs[3][2], ocs[4][2], ocs[5][2], ocs[6][2]}),
            32'b110001);
        chk("lock_15", 32'(lks[15]), 32'd0);
        chk("lock_16", 32'(lks[16]), 32'd1);

        // ch1 D=8 P=3.
        wr(1, 8, 3);
        chk("wr_unlock", 32'(lk), 32'd0);
        record(24);
        chk("d8_en", 32'({ens[3][1], ens[4][1], ens[5][1], ens[12][1], ens[13][1], ens[20][1]}),
            32'b010101);
        chk("d8_oc", 32'({ocs[1][1], ocs[4][1], ocs[5][1], ocs[8][1], ocs[9][1]}), 32'b11001);
        chk("d8_lock15", 32'(lks[15]), 32'd0);
        chk("d8_lock16", 32'(lks[16]), 32'd1);

        // Out-of-range phase clamps to 0; D=0 disables the channel.
        wr(2, 6, 9);
        record(10);
        chk("p9_en", 32'({ens[1][2], ens[2][2], ens[6][2], ens[7][2]}), 32'b1001);
        wr(0, 0, 0);
        record(8);
        for (int k = 1; k <= 8; k++) begin
            chk("d0_off", 32'({ens[k][0], ocs[k][0]}), 32'd0);
        end

        // Writes at cycles 0, 5, 10 and an invalid select at 12.
        for (int c = 0; c <= 30; c++) begin
            we   = (c == 0) || (c == 5) || (c == 10) || (c == 12);
            sel  = (c == 12) ? 2'd3 : 2'd1;
            cdiv = DW'(3 + c);
            cph  = DW'(1);
            tick();
            lks[c] = lk;
        end
        we = 1'b0;
        chk("bb_lock25", 32'(lks[25]), 32'd0);
        chk("bb_lock26", 32'(lks[26]), 32'd1);

        // Reset coincident with a write: reset wins, defaults return.
        rst  = 1'b1;
        we   = 1'b1;
        sel  = 2'd1;
        cdiv = DW'(9);
        cph  = '0;
        tick();
        chk("rw_zero", 32'({en, oc, lk}), 32'd0);
        rst = 1'b0;
        we  = 1'b0;
        tick();
        chk("rw_en", 32'(en), 32'b111);
        chk("rw_oc1", 32'(oc), 32'b110);
        tick();
        chk("rw_oc2", 32'(oc), 32'b100);

        // Random soak against the model.
        for (int n = 0; n < 4000; n++) begin
            int r;
            r    = int'($urandom_range(0, 199));
            rst  = (r == 0);
            we   = (r >= 1) && (r <= 4);
            sel  = 2'($urandom_range(0, 3));
            cdiv = DW'($urandom_range(0, 12));
            cph  = DW'($urandom_range(0, 14));
            tick();
        end
        rst = 1'b0;
        we  = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
